snake_body_writer: RTL
======================

Name: snake_body_writer

Overview:
- Write-side owner of the snake body store for the Snake Game Arcade datapath.
- On each `move` strobe it:
  - computes the next head cell from the latched direction;
  - checks wall and self collision;
  - writes the new head into a circular position buffer;
  - drops or keeps the tail (grow on apple).
- The render path reads positions back through a synchronous read port with the same 1-cycle latency as the body ROM it replaces.

Parameters:
- GRID_W, 6, grid columns.
- GRID_H, 6, grid rows.
- POS_W, 6, position width; position = row*GRID_W + col.
- MAX_LEN, 16, buffer depth / maximum snake length (power of 2).
- INIT_POS, 14, head cell after reset (row 2, col 2).

Ports:
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous active-high reset.
- buttons, in, 4, one-hot direction request: [0]=up, [1]=left, [2]=down, [3]=right.
- move, in, 1, step request pulse.
- apple_pos, in, POS_W, current apple cell.
- rd_index, in, log2(MAX_LEN), body offset from head (0=head).
- rd_pos, out, POS_W, position at rd_index, registered.
- size, out, log2(MAX_LEN)+1, current length.
- busy, out, 1, step in progress.
- done, out, 1, one-cycle pulse when a step commits.
- ate, out, 1, pulse with done when the head landed on apple_pos.
- game_over, out, 1, sticky collision flag.
- db_head, out, POS_W, current head position.

Behaviour:
- Reset values:
  - size=1, slot[head]=INIT_POS, dir=right;
  - busy=0, done=0, ate=0, game_over=0;
  - rd_pos=0 on the cycle after reset, then normal reads;
  - db_head=INIT_POS.
- Reset mid-step aborts the step; nothing is committed.
- Direction register:
  - Updated every cycle (any state) when buttons has exactly one bit set and it is not the reverse of the direction committed by the last step.
  - Zero, multi-bit or reversing inputs are ignored.
- FSM states: IDLE, CALC, CHECK, WRITE, DONE, DEAD.
- IDLE:
  - move=1 and game_over=0 -> CALC.
  - move in any other state is ignored, not queued.
- CALC:
  - Compute next = head ± 1 or ± GRID_W.
  - Edge crossing (col 0 left, col GRID_W-1 right, row 0 up, row GRID_H-1 down) -> game_over=1, state DEAD.
  - Otherwise grow = (next==apple_pos) && size<MAX_LEN.
  - N = size if grow, else size-1 (the tail vacates).
  - N=0 -> WRITE, else CHECK.
- CHECK:
  - Compares next against body entry k, one per cycle, for k=0..N-1.
  - On a match -> game_over=1, DEAD.
  - After k=N-1 -> WRITE.
- WRITE:
  - Head pointer decrements modulo MAX_LEN; slot[new head]=next.
  - If grow, size+=1.
  - ate is registered = (next==apple_pos), so it is also 1 when at MAX_LEN (size saturates, tail still drops).
- DONE: done=1 and ate valid for exactly this cycle; -> IDLE.
- Latency: move sampled in cycle T -> done high in cycle T+3+N; busy=1 from T+1 through T+3+N.
- DEAD: busy=0, no steps accepted; leaves only on reset.
- Read port:
  - rd_pos = slot[(head+rd_index) mod MAX_LEN], one cycle after rd_index.
  - Reads return pre-step contents until the WRITE edge.
  - rd_index ≥ size returns a stale slot; the renderer bounds reads by size.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: edge crossing wraps to the opposite edge in the same row/column (col 5 right -> col 0; row 0 up -> row 5). No wall collision; self-collision checking is unchanged.
- Undefined: edge crossing sets game_over as above.

Decomposition:
- Package sga_pkg holds:
  - direction encoding constants (DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT) and the reverse-lookup function;
  - GRID_W/GRID_H defaults;
  - the FSM state enum.
- One sub-module, snake_pos_ram:
  - MAX_LEN x POS_W register array;
  - one write port, one registered read port for rd_index, one combinational scan port for CHECK.

Test Plan:
- Reset, move with buttons idle -> done at T+3, db_head=15, size=1, ate=0; rd_index=0 -> rd_pos=15 next cycle.
- apple_pos=16, head 15 moving right, move -> done at T+4 (N=1), ate=1, size=2, rd_pos(0)=16, rd_pos(1)=15.
- Direction right, press buttons=4'b0010 (left), move -> reversal ignored, head advances +1.
- Head 17 (col 5) moving right, move:
  - without SNAKE_WRAP_EN -> game_over=1, done never pulses, later move ignored;
  - with SNAKE_WRAP_EN -> head=12, done pulses.
- Grow to size 5, then steer down, left, up into the body -> game_over=1 during CHECK; reset -> size=1, head=14, game_over=0.
- Assert reset during CHECK -> next cycle busy=0, size=1, db_head=14, no done pulse.

Source files
------------

// File: rtl/sga_pkg.sv
// sga_pkg: shared direction encoding, grid defaults and FSM states for the
// Snake Game Arcade datapath.
package sga_pkg;

   localparam int DEF_GRID_W = 6;
   localparam int DEF_GRID_H = 6;

   // One-hot direction, bit order matches the buttons input.
   typedef logic [3:0] dir_t;
   localparam dir_t DIR_UP    = 4'b0001;
   localparam dir_t DIR_LEFT  = 4'b0010;
   localparam dir_t DIR_DOWN  = 4'b0100;
   localparam dir_t DIR_RIGHT = 4'b1000;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      CHECK,
      WRITE,
      DONE,
      DEAD
   } state_t;

   function automatic dir_t reverse_dir(input dir_t d);
      dir_t r;
      case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_DOWN:  r = DIR_UP;
         DIR_RIGHT: r = DIR_LEFT;
         default:   r = 4'b0000;
      endcase
      return r;
   endfunction

   function automatic logic is_onehot(input logic [3:0] b);
      return (b != 4'b0000) && ((b & (b - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/snake_pos_ram.sv
// snake_pos_ram: circular body position store with one write port, one
// registered render read port and one combinational collision scan port.
module snake_pos_ram
   import sga_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int POS_W = 6,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [POS_W-1:0] wdata,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [POS_W-1:0] rd_pos,
   input  logic [IDX_W-1:0] scan_addr,
   output logic [POS_W-1:0] scan_pos
);

   logic [POS_W-1:0] mem [DEPTH];

   // Body storage write, one slot per cycle.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   // NOTE: the array itself is not reset; the owner seeds the head slot by writing during reset.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered render read, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) rd_pos <= '0;
      else       rd_pos <= mem[rd_addr];
   end

   assign scan_pos = mem[scan_addr];

endmodule

// File: rtl/snake_body_writer.sv
// snake_body_writer: steps the snake on each move strobe, checks wall and
// self collision, and maintains the circular body buffer.
// Build option: define SNAKE_WRAP_EN to wrap at grid edges instead of dying.
module snake_body_writer
   import sga_pkg::*;
#(
   parameter int GRID_W   = DEF_GRID_W,
   parameter int GRID_H   = DEF_GRID_H,
   parameter int POS_W    = 6,
   parameter int MAX_LEN  = 16,
   parameter int INIT_POS = 14,
   localparam int IDX_W   = $clog2(MAX_LEN),
   localparam int SIZE_W  = IDX_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        buttons,
   input  logic              move,
   input  logic [POS_W-1:0]  apple_pos,
   input  logic [IDX_W-1:0]  rd_index,
   output logic [POS_W-1:0]  rd_pos,
   output logic [SIZE_W-1:0] size,
   output logic              busy,
   output logic              done,
   output logic              ate,
   output logic              game_over,
   output logic [POS_W-1:0]  db_head
);

`ifdef SNAKE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   localparam logic [POS_W-1:0] INIT_ROW = POS_W'(INIT_POS / GRID_W);
   localparam logic [POS_W-1:0] INIT_COL = POS_W'(INIT_POS % GRID_W);
   localparam logic [POS_W-1:0] LAST_ROW = POS_W'(GRID_H - 1);
   localparam logic [POS_W-1:0] LAST_COL = POS_W'(GRID_W - 1);

   state_t            state, state_nxt;
   dir_t              dir, last_dir, step_dir;
   logic [IDX_W-1:0]  hp;
   logic [POS_W-1:0]  head_row, head_col;
   logic [POS_W-1:0]  next_pos, next_row, next_col;
   logic              eat_q, grow_q, ate_q;
   logic [SIZE_W-1:0] n_q, k_q;

   logic [POS_W-1:0]  cand_row, cand_col, cand_pos;
   logic              edge_hit, wall, cand_eat, cand_grow;
   logic [SIZE_W-1:0] cand_n;

   logic              ram_we;
   logic [IDX_W-1:0]  ram_waddr;
   logic [POS_W-1:0]  ram_wdata;
   logic [POS_W-1:0]  scan_pos;
   logic              hit;

   // Candidate next head from the committed head and the latched direction.
   always_comb begin
      cand_row = head_row;
      cand_col = head_col;
      edge_hit = 1'b0;
      case (dir)
         DIR_UP: begin
            edge_hit = (head_row == '0);
            cand_row = edge_hit ? LAST_ROW : head_row - POS_W'(1);
         end
         DIR_DOWN: begin
            edge_hit = (head_row == LAST_ROW);
            cand_row = edge_hit ? '0 : head_row + POS_W'(1);
         end
         DIR_LEFT: begin
            edge_hit = (head_col == '0);
            cand_col = edge_hit ? LAST_COL : head_col - POS_W'(1);
         end
         DIR_RIGHT: begin
            edge_hit = (head_col == LAST_COL);
            cand_col = edge_hit ? '0 : head_col + POS_W'(1);
         end
         default: ;
      endcase
      wall      = edge_hit && !WRAP_EN;
      cand_pos  = POS_W'(int'(cand_row) * GRID_W + int'(cand_col));
      cand_eat  = (cand_pos == apple_pos);
      cand_grow = cand_eat && (size < SIZE_W'(MAX_LEN));
      // Without growth the tail slot is vacated, so it is not a collision.
      cand_n    = cand_grow ? size : size - SIZE_W'(1);
   end

   assign hit = (scan_pos == next_pos);

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state and step status outputs.
   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      ate       = 1'b0;
      case (state)
         IDLE: begin
            if (move && !game_over) state_nxt = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (wall)                 state_nxt = DEAD;
            else if (cand_n == '0)    state_nxt = WRITE;
            else                      state_nxt = CHECK;
         end
         CHECK: begin
            busy = 1'b1;
            if (hit)                                state_nxt = DEAD;
            else if (k_q == n_q - SIZE_W'(1))       state_nxt = WRITE;
         end
         WRITE: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            ate       = ate_q;
            state_nxt = IDLE;
         end
         DEAD: ;
         default: state_nxt = IDLE;
      endcase
   end

   // Direction latch, step bookkeeping and committed snake state.
   always_ff @(posedge clock) begin
      if (reset) begin
         dir       <= DIR_RIGHT;
         last_dir  <= DIR_RIGHT;
         step_dir  <= DIR_RIGHT;
         hp        <= '0;
         size      <= SIZE_W'(1);
         db_head   <= POS_W'(INIT_POS);
         head_row  <= INIT_ROW;
         head_col  <= INIT_COL;
         next_pos  <= '0;
         next_row  <= '0;
         next_col  <= '0;
         eat_q     <= 1'b0;
         grow_q    <= 1'b0;
         ate_q     <= 1'b0;
         n_q       <= '0;
         k_q       <= '0;
         game_over <= 1'b0;
      end else begin
         // Reversal is judged against the direction of the last committed step.
         if (is_onehot(buttons) && (buttons != reverse_dir(last_dir))) dir <= buttons;
         if ((state != DEAD) && (state_nxt == DEAD)) game_over <= 1'b1;
         case (state)
            CALC: begin
               next_pos <= cand_pos;
               next_row <= cand_row;
               next_col <= cand_col;
               eat_q    <= cand_eat;
               grow_q   <= cand_grow;
               n_q      <= cand_n;
               k_q      <= '0;
               step_dir <= dir;
            end
            CHECK: k_q <= k_q + SIZE_W'(1);
            WRITE: begin
               hp       <= hp - IDX_W'(1);
               db_head  <= next_pos;
               head_row <= next_row;
               head_col <= next_col;
               size     <= size + SIZE_W'(grow_q);
               last_dir <= step_dir;
               ate_q    <= eat_q;
            end
            default: ;
         endcase
      end
   end

   // Reset seeds slot 0 with the start cell; WRITE pushes the new head.
   assign ram_we    = reset || (state == WRITE);
   assign ram_waddr = reset ? '0 : hp - IDX_W'(1);
   assign ram_wdata = reset ? POS_W'(INIT_POS) : next_pos;

   snake_pos_ram #(
      .DEPTH (MAX_LEN),
      .POS_W (POS_W)
   ) u_ram (
      .clock     (clock),
      .reset     (reset),
      .we        (ram_we),
      .waddr     (ram_waddr),
      .wdata     (ram_wdata),
      .rd_addr   (hp + rd_index),
      .rd_pos    (rd_pos),
      .scan_addr (hp + k_q[IDX_W-1:0]),
      .scan_pos  (scan_pos)
   );

endmodule
